// File: rtl/exe_pkg.sv
// Shared types for the execute pipeline: opcodes, FSM states and flag bit positions.
package exe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_pipe_alu.sv
// Combinational single-cycle ALU: arithmetic, logic and shift ops with {N,Z,C,V}.
module alu
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic [SH_W-1:0]  amt;
  logic             carry;
  logic             ovf;

  // Shifts use a one-bit extension so the last bit shifted out lands in the spare bit.
  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    amt   = b[SH_W-1:0];
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        wide  = {1'b0, a} << amt;
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_SHR: begin
        wide  = {a, 1'b0} >> amt;
        res   = wide[WIDTH:1];
        carry = wide[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    result         = res;
    flags          = '0;
    flags[FLAG_N]  = res[WIDTH-1];
    flags[FLAG_Z]  = (res == '0);
    flags[FLAG_C]  = carry;
    flags[FLAG_V]  = ovf;
  end

endmodule

// File: rtl/exe_pipe.sv
// Execute stage: single-cycle ALU ops plus an optional iterative shift-add multiplier,
// with a valid/ready handshake on both sides.
module exe_pipe
  import exe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic [WIDTH-1:0] immediate,
  input  logic [2:0]       alu_oc,
  input  logic             ir_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state, state_next;
  alu_op_e            op;
  logic [WIDTH-1:0]   op2, alu_result, mcand;
  logic [3:0]         alu_flags, mul_flags;
  logic [2*WIDTH-1:0] prod, prod_next;
  logic [WIDTH:0]     mul_sum;
  logic [CNT_W-1:0]   iter;
  logic               accept, is_mul, start_mul, last_iter;

  assign op        = alu_op_e'(alu_oc);
  assign op2       = ir_op ? value2 : immediate;
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign start_mul = accept && is_mul && (MUL_EN != 0);
  assign last_iter = (state == ST_MUL) && (iter == LAST_ITER);
  assign busy      = (state == ST_MUL);

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (value1),
    .b      (op2),
    .op     (op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // prod holds {partial sum, remaining multiplier bits}; each step adds and shifts right.
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = prod_next[WIDTH-1];
    mul_flags[FLAG_Z] = (prod_next[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = (prod_next[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_mul) state_next = ST_MUL;
      ST_MUL:  if (last_iter) state_next = out_ready ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output registers only move on a fresh result or a consumed one, so a stall holds them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      mcand     <= '0;
      prod      <= '0;
      iter      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !start_mul) begin
            result    <= is_mul ? '0 : alu_result;
            flags     <= is_mul ? '0 : alu_flags;
            out_valid <= 1'b1;
          end else begin
            if (out_ready) out_valid <= 1'b0;
            if (start_mul) begin
              mcand <= value1;
              prod  <= {{WIDTH{1'b0}}, op2};
              iter  <= '0;
            end
          end
        end
        ST_MUL: begin
          prod <= prod_next;
          iter <= iter + CNT_W'(1);
          if (last_iter) begin
            result    <= prod_next[WIDTH-1:0];
            flags     <= mul_flags;
            out_valid <= 1'b1;
            iter      <= '0;
          end
        end
        ST_HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_pipe.sv
// Self-checking bench for exe_pipe: directed vector table, multi-cycle corner sequences
// and a randomized stream scored against an arithmetic reference model.
module tb_exe_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, ir_op, out_valid, out_ready, busy;
  logic [W-1:0]  value1, value2, immediate, result;
  logic [2:0]    alu_oc;
  logic [3:0]    flags;

  int checks = 0;
  int errors = 0;

  logic [35:0] sb_q[$];
  int          pops;
  logic        prev_stall;
  logic [35:0] prev_out;

  typedef struct {
    logic [2:0]  op;
    logic        ir;
    logic [31:0] v1, v2, imm, exp_res;
    logic [3:0]  exp_flags;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  exe_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value1    (value1),
    .value2    (value2),
    .immediate (immediate),
    .alu_oc    (alu_oc),
    .ir_op     (ir_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic; flags packed {N,Z,C,V}.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, s;
    logic [63:0] w;
    int amt;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b[4:0]);
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin w = {32'b0, a} + {32'b0, b}; r = w[31:0]; c = w[32];
                  s = sa + sb; v = (s != longint'($signed(r))); end
      3'd1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s != longint'($signed(r))); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << amt; c = (amt == 0) ? 1'b0 : a[32 - amt]; end
      3'd6: begin r = a >> amt; c = (amt == 0) ? 1'b0 : a[amt - 1]; end
      default: begin w = {32'b0, a} * {32'b0, b}; r = w[31:0]; c = (w[63:32] != 0); end
    endcase
    f = {r[31], (r == 0), c, v};
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic ir, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] imm);
    @(negedge clk);
    alu_oc = op; ir_op = ir; value1 = v1; value2 = v2; immediate = imm;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready_at_issue", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_result"}, result, exp_res);
    check({name, "_flags"}, flags, exp_flags);
  endtask

  // One handshake cycle of the streaming scoreboard; also checks stall stability.
  task automatic stepCycle(input logic iv, input logic [2:0] op, input logic ir, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] imm, input logic ordy,
                           output logic accepted);
    logic [31:0] r;
    logic [3:0]  f;
    logic [35:0] exp;
    @(negedge clk);
    in_valid = iv; alu_oc = op; ir_op = ir; value1 = v1; value2 = v2; immediate = imm;
    out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_stable", {flags, result}, prev_out);
    end
    accepted = iv && in_ready;
    if (accepted) begin
      model(op, v1, ir ? v2 : imm, r, f);
      sb_q.push_back({f, r});
    end
    if (out_valid && ordy) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL unexpected_output actual=%h required=none", {flags, result});
      end else begin
        exp = sb_q.pop_front();
        check("stream_output", {flags, result}, exp);
        pops++;
      end
    end
    prev_stall = out_valid && !ordy;
    prev_out   = {flags, result};
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    #1;
  endtask

  task automatic resetStream();
    sb_q.delete();
    pops = 0;
    prev_stall = 1'b0;
    prev_out = '0;
  endtask

  initial begin
    logic acc;
    int cycles, busy_cnt, ready_seen, issued;
    logic seen_valid;
    logic [31:0] corner[5];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ir_op = 1'b0; alu_oc = '0;
    value1 = '0; value2 = '0; immediate = '0;
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1;
    resetStream();

    vecs.push_back('{3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0,        32'h1,  32'h0000_0000, 4'b0110});
    vecs.push_back('{3'd1, 1'b1, 32'h8000_0000, 32'h1,        32'h0,  32'h7FFF_FFFF, 4'b0011});
    vecs.push_back('{3'd5, 1'b0, 32'h8000_0001, 32'h0,        32'h1,  32'h0000_0002, 4'b0010});
    vecs.push_back('{3'd5, 1'b0, 32'h8000_0001, 32'h5,        32'h0,  32'h8000_0001, 4'b1000});
    vecs.push_back('{3'd5, 1'b0, 32'h0000_0001, 32'h0,        32'h20, 32'h0000_0001, 4'b0000});
    vecs.push_back('{3'd2, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h00F0_00F0, 4'b0000});
    vecs.push_back('{3'd3, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 4'b0100});
    vecs.push_back('{3'd4, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0, 32'hFFFF_FFFF, 4'b1000});
    vecs.push_back('{3'd6, 1'b0, 32'h0000_0003, 32'h0,        32'h2,  32'h0000_0000, 4'b0110});
    vecs.push_back('{3'd0, 1'b1, 32'h7FFF_FFFF, 32'h1,        32'h0,  32'h8000_0000, 4'b1001});
    vecs.push_back('{3'd1, 1'b1, 32'h0000_0005, 32'h5,        32'h0,  32'h0000_0000, 4'b0110});
    vecs.push_back('{3'd1, 1'b0, 32'h0000_0003, 32'h0,        32'h5,  32'hFFFF_FFFE, 4'b1000});

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].ir, vecs[i].v1, vecs[i].v2, vecs[i].imm);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_flags);
    end
    idleCycles(2);

    // MUL with overflow out of the low word: WIDTH busy cycles then a result.
    applyStimulus(3'd7, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0);
    cycles = 1; busy_cnt = 0; ready_seen = 0;
    while (!out_valid && cycles < 40) begin
      if (busy) busy_cnt++;
      if (in_ready) ready_seen++;
      @(posedge clk);
      #1;
      cycles++;
    end
    check("mul_latency", cycles, 33);
    check("mul_busy_cycles", busy_cnt, 32);
    check("mul_in_ready_low", ready_seen, 0);
    check("mul_busy_done", busy, 0);
    checkOutput("mul_big", 32'h0, 4'b0110);
    idleCycles(2);

    // MUL finishing into a stalled consumer parks in HOLD.
    applyStimulus(3'd7, 1'b0, 32'd3, 32'd0, 32'd5);
    out_ready = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("mul_hold", 32'd15, 4'b0000);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, 15);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready, 1);

    // Five back-to-back ADDs against an alternating consumer.
    resetStream();
    issued = 0;
    for (int cyc = 0; cyc < 40 && (issued < 5 || sb_q.size() > 0 || out_valid); cyc++) begin
      stepCycle(issued < 5, 3'd0, 1'b1, 32'd100 + 32'(issued), 32'(issued * 7), 32'h0,
                (cyc % 2) == 0, acc);
      if (acc) issued++;
    end
    check("b2b_issued", issued, 5);
    check("b2b_delivered", pops, 5);
    idleCycles(2);

    // Reset in the middle of a multiply discards it.
    applyStimulus(3'd7, 1'b1, 32'd7, 32'd9, 32'h0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_valid", out_valid, 0);
    check("midreset_result", result, 0);
    check("midreset_flags", flags, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_ready", in_ready, 1);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("midreset_no_output", seen_valid, 0);

    // Randomized stream with random backpressure, including occasional multiplies.
    resetStream();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [2:0]  rop;
      logic [31:0] a, b, c;
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd7 && ($urandom % 4) != 0) rop = 3'd0;
      a = ($urandom % 4 == 0) ? corner[$urandom % 5] : $urandom;
      b = ($urandom % 4 == 0) ? corner[$urandom % 5] : $urandom;
      c = ($urandom % 2 == 0) ? 32'($urandom_range(0, 33)) : $urandom;
      stepCycle(($urandom % 4) != 0, rop, 1'($urandom % 2), a, b, c, ($urandom % 3) != 0, acc);
    end
    for (int cyc = 0; cyc < 60 && (sb_q.size() > 0 || out_valid); cyc++)
      stepCycle(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    check("random_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
